// File: rtl/div_iter_n.sv
// div_iter_n: iterative radix-2 restoring divider (DIV/DIVU/REM/REMU).
// Divide-by-zero and signed overflow are resolved at accept time and go
// straight to HOLD. Normal operations run one quotient bit per cycle in BUSY.
// The result then waits in HOLD until it is consumed or flushed.
// Optional feature: define DIV_EARLY_OUT_EN to skip the leading zeros of |a|.
// The quotient and remainder are the same with or without this feature.
module div_iter_n #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic [TAG_W-1:0] out_tag
);

    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // dvd: shifting dividend, dvs: |divisor|, rem: partial remainder, quo: quotient
    logic [WIDTH-1:0] dvd_reg, dvd_next;
    logic [WIDTH-1:0] dvs_reg, dvs_next;
    logic [WIDTH-1:0] rem_reg, rem_next;
    logic [WIDTH-1:0] quo_reg, quo_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             qneg_reg, qneg_next;
    logic             rneg_reg, rneg_next;
    logic             sel_rem_reg, sel_rem_next;
    logic [TAG_W-1:0] tag_reg, tag_next;

    logic             accept;
    logic             op_signed;
    logic             a_neg;
    logic             b_neg;
    logic             div_zero;
    logic             sig_ovf;
    logic             a_zero;
    logic             special;
    logic             last_iter;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH-1:0] load_dvd;
    logic [CNT_W-1:0] load_cnt;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    // Handshake: a new op may enter whenever the slot is empty, being
    // vacated by the consumer, or being killed by flush.
    assign in_ready  = (state_reg == IDLE) | flush | ((state_reg == HOLD) & out_ready);
    assign out_valid = (state_reg == HOLD) & ~flush;
    assign accept    = in_valid & in_ready;

    // Operand preparation: signed ops work on magnitudes, signs fixed at the end
    assign op_signed = ~in_op[0];
    assign a_neg     = op_signed & in_a[WIDTH-1];
    assign b_neg     = op_signed & in_b[WIDTH-1];
    assign abs_a     = a_neg ? -in_a : in_a;
    assign abs_b     = b_neg ? -in_b : in_b;
    assign div_zero  = (in_b == '0);
    assign sig_ovf   = op_signed & (in_a == MIN_NEG) & (in_b == ALL_ONES);

`ifdef DIV_EARLY_OUT_EN
    logic [WIDTH-1:0] any_above;
    logic [CNT_W-1:0] lz;

    // any_above[i] is set when |a| has a one at bit i or higher
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lz
        assign any_above[gi] = |abs_a[WIDTH-1:gi];
    end

    // Leading-zero count: every position with nothing above it is a leading zero
    always_comb begin
        lz = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (!any_above[i]) begin
                lz = lz + CNT_ONE;
            end
        end
    end

    assign load_dvd = abs_a << lz;
    assign load_cnt = CNT_FULL - lz;
    assign a_zero   = (abs_a == '0);
`else
    assign load_dvd = abs_a;
    assign load_cnt = CNT_FULL;
    assign a_zero   = 1'b0;
`endif

    assign special   = div_zero | sig_ovf | a_zero;

    // Restoring step: try to subtract the divisor from {rem, next dividend bit}
    assign trial     = {rem_reg, dvd_reg[WIDTH-1]} - {1'b0, dvs_reg};
    assign last_iter = (cnt_reg == CNT_ONE);

    // Sign correction of the held result
    assign quo_fix = qneg_reg ? -quo_reg : quo_reg;
    assign rem_fix = rneg_reg ? -rem_reg : rem_reg;
    assign out_res = sel_rem_reg ? rem_fix : quo_fix;
    assign out_tag = tag_reg;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: accept wins, then flush, then normal progress
    always_comb begin
        state_next = state_reg;
        if (accept) begin
            state_next = special ? HOLD : BUSY;
        end else if (flush) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                BUSY:    if (last_iter) state_next = HOLD;
                HOLD:    if (out_ready) state_next = IDLE;
                default: state_next = state_reg;
            endcase
        end
    end

    // Datapath next values: load on accept, iterate in BUSY, hold otherwise
    always_comb begin
        dvd_next     = dvd_reg;
        dvs_next     = dvs_reg;
        rem_next     = rem_reg;
        quo_next     = quo_reg;
        cnt_next     = cnt_reg;
        qneg_next    = qneg_reg;
        rneg_next    = rneg_reg;
        sel_rem_next = sel_rem_reg;
        tag_next     = tag_reg;
        if (accept) begin
            sel_rem_next = in_op[1];
            tag_next     = in_tag;
            dvs_next     = abs_b;
            dvd_next     = '0;
            cnt_next     = '0;
            // Special results are already final, so no sign correction applies
            qneg_next    = 1'b0;
            rneg_next    = 1'b0;
            if (div_zero) begin
                quo_next = ALL_ONES;
                rem_next = in_a;
            end else if (sig_ovf) begin
                quo_next = in_a;
                rem_next = '0;
            end else if (a_zero) begin
                quo_next = '0;
                rem_next = '0;
            end else begin
                quo_next  = '0;
                rem_next  = '0;
                dvd_next  = load_dvd;
                cnt_next  = load_cnt;
                qneg_next = a_neg ^ b_neg;
                rneg_next = a_neg;
            end
        end else if ((state_reg == BUSY) && !flush) begin
            if (!trial[WIDTH]) begin
                rem_next = trial[WIDTH-1:0];
            end else begin
                rem_next = {rem_reg[WIDTH-2:0], dvd_reg[WIDTH-1]};
            end
            quo_next = {quo_reg[WIDTH-2:0], ~trial[WIDTH]};
            dvd_next = {dvd_reg[WIDTH-2:0], 1'b0};
            cnt_next = cnt_reg - CNT_ONE;
        end
    end

    // Datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dvd_reg     <= '0;
            dvs_reg     <= '0;
            rem_reg     <= '0;
            quo_reg     <= '0;
            cnt_reg     <= '0;
            qneg_reg    <= 1'b0;
            rneg_reg    <= 1'b0;
            sel_rem_reg <= 1'b0;
            tag_reg     <= '0;
        end else begin
            dvd_reg     <= dvd_next;
            dvs_reg     <= dvs_next;
            rem_reg     <= rem_next;
            quo_reg     <= quo_next;
            cnt_reg     <= cnt_next;
            qneg_reg    <= qneg_next;
            rneg_reg    <= rneg_next;
            sel_rem_reg <= sel_rem_next;
            tag_reg     <= tag_next;
        end
    end

endmodule
